// File: rtl/arb_pkg.sv
// Shared types and the round-robin search helper for rr_grant_arbiter.
// The optional lock input is enabled by defining ARB_LOCK_EN.
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_N = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } pick_t;

  // Searches req starting just above ptr and wrapping at n; the first set bit wins.
  // ptr < n and k <= n keep j below 2n, so one conditional subtract is enough.
  function automatic pick_t rr_next(input logic [MAX_N-1:0] req,
                                    input logic [3:0]       ptr,
                                    input int               n);
    pick_t res;
    int    j;
    res = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!res.valid && req[j[3:0]]) begin
          res.valid = 1'b1;
          res.idx   = j[3:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate-and-priority-encode r from ptr+1.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  r,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [MAX_N-1:0] req_w;
  logic [3:0]       ptr_w;
  pick_t            pk;
  logic             unused_bits;

  // Widen to the helper's fixed width and run the search.
  always_comb begin
    req_w          = '0;
    req_w[N-1:0]   = r;
    ptr_w          = '0;
    ptr_w[IW-1:0]  = ptr;
    pk             = rr_next(req_w, ptr_w, N);
  end

  assign valid       = pk.valid;
  assign idx         = pk.idx[IW-1:0];
  assign unused_bits = &{1'b0, pk.idx};

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grants and a hold limit.
// Define ARB_LOCK_EN to add a lock input that suppresses forced release.
//
// state | meaning
// IDLE  | no grant; g=0; pick next requester after ptr
// GRANT | g=onehot(gid); held while r[gid] stays high, up to the hold limit
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  r,
`ifdef ARB_LOCK_EN
  input  logic          lock,
`endif
  output logic [N-1:0]  g,
  output logic [IW-1:0] gid,
  output logic          busy,
  output logic          timeout
);

  // hold_left is a down-counter: loaded at grant with MAX_HOLD-1, the limit is
  // reached when it hits zero, where it then saturates.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;
  localparam logic [N-1:0]  ONE       = N'(1);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] hold_left;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          hold_lock;
  logic          others;

`ifdef ARB_LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  assign others = (r & ~g) != '0;

  rr_pick #(.N(N)) u_pick (
    .r     (r),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      g         <= '0;
      gid       <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= IW'(N - 1);
      hold_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (pick_valid) begin
            state     <= GRANT;
            g         <= ONE << pick_idx;
            gid       <= pick_idx;
            busy      <= 1'b1;
            hold_left <= HOLD_LOAD;
          end
        end
        GRANT: begin
          if (!r[gid]) begin
            state   <= IDLE;
            g       <= '0;
            busy    <= 1'b0;
            ptr     <= gid;
            timeout <= 1'b0;
          end else if (MAX_HOLD != 0 && hold_left == '0 && others && !hold_lock) begin
            state   <= IDLE;
            g       <= '0;
            busy    <= 1'b0;
            ptr     <= gid;
            timeout <= 1'b1;
          end else if (hold_left != '0) begin
            hold_left <= hold_left - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          g       <= '0;
          busy    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule
